// File: rtl/io_scan_dma_pkg.sv
// -----------------------------------------------------------------------------
// io_scan_dma_pkg
//   Shared definitions for the PLC I/O scan engine:
//     - scan FSM state encodings
//     - MODE field constants and decode helpers
//     - clog2 / counter-width helpers used at elaboration time
// -----------------------------------------------------------------------------
package io_scan_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_IN   = 3'd1,
    ST_RD_OUT  = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_FIN     = 3'd4
  } scan_state_t;

  // MODE field: 00 inputs only, 01 outputs only, 1x inputs then outputs.
  localparam logic [1:0] MODE_IN   = 2'b00;
  localparam logic [1:0] MODE_OUT  = 2'b01;
  localparam logic [1:0] MODE_BOTH = 2'b10;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Width of a counter that indexes max(a,b) items, never narrower than 1 bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    int w;
    m = (a > b) ? a : b;
    w = clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

  // A scan writes the input image for every mode except outputs-only.
  function automatic logic mode_has_in(input logic [1:0] m);
    return (m != MODE_OUT);
  endfunction

  // A scan reads the output image for outputs-only and for both 1x codes.
  function automatic logic mode_has_out(input logic [1:0] m);
    return (m == MODE_OUT) || ((m & MODE_BOTH) == MODE_BOTH);
  endfunction

endpackage

// File: rtl/io_scan_dma.sv
// -----------------------------------------------------------------------------
// io_scan_dma
//   DMA scan engine between the PLC physical I/O pins and the 1-bit-wide image
//   memory. Each accepted SCAN_REQ snapshots PIN and writes it bit-serially to
//   the input image, reads the output image back into a shadow register and
//   then commits all outputs to POUT in one edge, so POUT never shows a
//   partially updated pattern. SAFE forces POUT to OUT_SAFE at every edge.
//
// Ports
//   CLK       in   1      clock, rising edge
//   CLR       in   1      synchronous reset, active-high
//   SCAN_REQ  in   1      start a scan (only looked at in IDLE)
//   MODE      in   2      00 inputs, 01 outputs, 1x both; latched with SCAN_REQ
//   SAFE      in   1      force POUT=OUT_SAFE, discard commit
//   BUSY      out  1      engine owns the image memory port
//   DONE      out  1      one-cycle pulse at scan end
//   PIN       in   N_IN   physical inputs (already synchronised)
//   POUT      out  N_OUT  registered physical outputs
//   IM_A      out  AW     image memory address
//   IM_DI     out  1      image write data
//   IM_WE     out  1      image write enable
//   IM_DQ     in   1      image read data, one cycle after IM_A
// -----------------------------------------------------------------------------
module io_scan_dma
  import io_scan_dma_pkg::*;
#(
  parameter int               N_IN     = 16,
  parameter int               N_OUT    = 16,
  parameter int               AW       = 5,
  parameter int               IN_BASE  = 0,
  parameter int               OUT_BASE = 16,
  parameter logic [N_OUT-1:0] OUT_RST  = '0,
  parameter logic [N_OUT-1:0] OUT_SAFE = '0
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             SCAN_REQ,
  input  logic [1:0]       MODE,
  input  logic             SAFE,
  output logic             BUSY,
  output logic             DONE,
  input  logic [N_IN-1:0]  PIN,
  output logic [N_OUT-1:0] POUT,
  output logic [AW-1:0]    IM_A,
  output logic             IM_DI,
  output logic             IM_WE,
  input  logic             IM_DQ
);

  // Shared scan counter covers the longer of the two bit phases.
  localparam int CW = cnt_width(N_IN, N_OUT);
  // Index widths that exactly fit the snapshot and shadow vectors.
  localparam int IW = cnt_width(N_IN, 1);
  localparam int OW = cnt_width(N_OUT, 1);

  localparam logic [CW-1:0] IN_LAST    = CW'(N_IN - 1);
  localparam logic [CW-1:0] OUT_LAST   = CW'(N_OUT - 1);
  localparam logic [AW-1:0] IN_BASE_A  = AW'(IN_BASE);
  localparam logic [AW-1:0] OUT_BASE_A = AW'(OUT_BASE);

  // Image ranges are fixed at build time, so a bad map is rejected at
  // elaboration instead of being checked in hardware.
  if ((N_IN < 1) || (N_OUT < 1) ||
      (IN_BASE + N_IN > (1 << AW)) || (OUT_BASE + N_OUT > (1 << AW))) begin : g_range_err
    $error("io_scan_dma: channel range does not fit the %0d-bit image address space", AW);
  end

  scan_state_t      state_reg;
  logic [1:0]       mode_reg;
  logic [CW-1:0]    cnt_reg;
  logic [N_IN-1:0]  snap_reg;
  logic [N_OUT-1:0] shadow_reg;

  logic [CW-1:0]    cnt_inc;
  logic [IW-1:0]    snap_idx;
  logic [OW-1:0]    shadow_idx;
  logic [N_OUT-1:0] commit_next;

  assign cnt_inc    = cnt_reg + 1'b1;
  // Address/data registers run one step ahead of the state, so the write
  // phase presents the bit for the *next* count value.
  assign snap_idx   = IW'(cnt_inc);
  // Read data lags the address by one cycle, so it lands one slot behind.
  assign shadow_idx = OW'(cnt_reg - 1'b1);

  // Last output bit arrives on IM_DQ in RD_WAIT; merge it straight into the
  // committed word rather than waiting another cycle for the shadow.
  always_comb begin
    commit_next          = shadow_reg;
    commit_next[N_OUT-1] = IM_DQ;
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_reg  <= ST_IDLE;
      mode_reg   <= MODE_IN;
      cnt_reg    <= '0;
      snap_reg   <= '0;
      shadow_reg <= '0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      IM_WE      <= 1'b0;
      IM_A       <= '0;
      IM_DI      <= 1'b0;
      POUT       <= OUT_RST;
    end else begin
      DONE <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (SCAN_REQ) begin
            snap_reg <= PIN;
            mode_reg <= MODE;
            cnt_reg  <= '0;
            BUSY     <= 1'b1;
            if (!mode_has_in(MODE)) begin
              state_reg <= ST_RD_OUT;
              IM_A      <= OUT_BASE_A;
              IM_WE     <= 1'b0;
              IM_DI     <= 1'b0;
            end else begin
              state_reg <= ST_WR_IN;
              IM_A      <= IN_BASE_A;
              IM_WE     <= 1'b1;
              IM_DI     <= PIN[0];
            end
          end
        end

        ST_WR_IN: begin
          if (cnt_reg == IN_LAST) begin
            cnt_reg <= '0;
            IM_WE   <= 1'b0;
            IM_DI   <= 1'b0;
            if (mode_has_out(mode_reg)) begin
              state_reg <= ST_RD_OUT;
              IM_A      <= OUT_BASE_A;
            end else begin
              state_reg <= ST_FIN;
              IM_A      <= '0;
              DONE      <= 1'b1;
            end
          end else begin
            cnt_reg <= cnt_inc;
            IM_A    <= IN_BASE_A + AW'(cnt_inc);
            IM_DI   <= snap_reg[snap_idx];
          end
        end

        ST_RD_OUT: begin
          if (cnt_reg != '0) begin
            shadow_reg[shadow_idx] <= IM_DQ;
          end
          if (cnt_reg == OUT_LAST) begin
            state_reg <= ST_RD_WAIT;
            cnt_reg   <= '0;
            IM_A      <= '0;
          end else begin
            cnt_reg <= cnt_inc;
            IM_A    <= OUT_BASE_A + AW'(cnt_inc);
          end
        end

        ST_RD_WAIT: begin
          shadow_reg[N_OUT-1] <= IM_DQ;
          if (!SAFE) begin
            POUT <= commit_next;
          end
          state_reg <= ST_FIN;
          DONE      <= 1'b1;
        end

        ST_FIN: begin
          state_reg <= ST_IDLE;
          BUSY      <= 1'b0;
        end

        default: begin
          state_reg <= ST_IDLE;
          BUSY      <= 1'b0;
          IM_WE     <= 1'b0;
          IM_A      <= '0;
          IM_DI     <= 1'b0;
        end
      endcase

      // Safe override wins over any commit made above in the same edge.
      if (SAFE) begin
        POUT <= OUT_SAFE;
      end
    end
  end

endmodule

// File: tb/tb_io_scan_dma.sv
`timescale 1ns/1ps
module tb_io_scan_dma;

  localparam int N_IN     = 16;
  localparam int N_OUT    = 16;
  localparam int IN_BASE  = 0;
  localparam int OUT_BASE = 16;
  localparam logic [15:0] OUT_RST  = 16'h5A5A;
  localparam logic [15:0] OUT_SAFE = 16'h0F0F;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT A (16/16) ----------------
  logic        clr, scan_req, safe, busy, done, im_di, im_we, im_dq;
  logic [1:0]  mode;
  logic [15:0] pin, pout;
  logic [4:0]  im_a;
  logic        ram0 [0:31];

  io_scan_dma #(
    .N_IN(N_IN), .N_OUT(N_OUT), .AW(5), .IN_BASE(IN_BASE), .OUT_BASE(OUT_BASE),
    .OUT_RST(OUT_RST), .OUT_SAFE(OUT_SAFE)
  ) dut (
    .CLK(clk), .CLR(clr), .SCAN_REQ(scan_req), .MODE(mode), .SAFE(safe),
    .BUSY(busy), .DONE(done), .PIN(pin), .POUT(pout),
    .IM_A(im_a), .IM_DI(im_di), .IM_WE(im_we), .IM_DQ(im_dq)
  );

  always @(posedge clk) begin
    if (im_we) ram0[im_a] <= im_di;
    im_dq <= ram0[im_a];
  end

  // ---------------- DUT B (4 in / 8 out, bases 20 / 2) ----------------
  logic        scan_req_b, safe_b, busy_b, done_b, im_di_b, im_we_b, im_dq_b;
  logic [1:0]  mode_b;
  logic [3:0]  pin_b;
  logic [7:0]  pout_b;
  logic [4:0]  im_a_b;
  logic        ram1 [0:31];

  io_scan_dma #(
    .N_IN(4), .N_OUT(8), .AW(5), .IN_BASE(20), .OUT_BASE(2),
    .OUT_RST(8'h00), .OUT_SAFE(8'h00)
  ) dut_b (
    .CLK(clk), .CLR(clr), .SCAN_REQ(scan_req_b), .MODE(mode_b), .SAFE(safe_b),
    .BUSY(busy_b), .DONE(done_b), .PIN(pin_b), .POUT(pout_b),
    .IM_A(im_a_b), .IM_DI(im_di_b), .IM_WE(im_we_b), .IM_DQ(im_dq_b)
  );

  always @(posedge clk) begin
    if (im_we_b) ram1[im_a_b] <= im_di_b;
    im_dq_b <= ram1[im_a_b];
  end

  // ---------------- checking infrastructure ----------------
  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // ---------------- behavioural model of DUT A ----------------
  // A scan is a timeline of L cycles after the accepting edge:
  //   [0, N_IN)        input bit t written (if mode writes inputs)
  //   next N_OUT       output bit reads
  //   +1               read-wait, commit at its closing edge
  //   last             DONE cycle
  bit          m_active = 1'b0;
  int          m_t      = 0;
  int          m_len    = 0;
  logic [1:0]  m_mode   = 2'b00;
  logic [15:0] m_snap   = 16'h0;
  logic [15:0] m_pout   = 16'h0;
  logic        m_img [0:31];

  function automatic bit f_has_in(input logic [1:0] m);
    return m != 2'b01;
  endfunction

  function automatic bit f_has_out(input logic [1:0] m);
    return m != 2'b00;
  endfunction

  function automatic int f_len(input logic [1:0] m);
    return (f_has_in(m) ? N_IN : 0) + (f_has_out(m) ? N_OUT + 1 : 0) + 1;
  endfunction

  task automatic model_step();
    // memory write performed during the cycle that this edge closes
    if (m_active && f_has_in(m_mode) && m_t < N_IN)
      m_img[(IN_BASE + m_t) % 32] = m_snap[m_t];
    if (clr) begin
      m_active = 1'b0;
      m_t      = 0;
      m_pout   = OUT_RST;
    end else begin
      if (m_active) begin
        if (f_has_out(m_mode) && m_t == m_len - 2)
          for (int i = 0; i < N_OUT; i++) m_pout[i] = m_img[(OUT_BASE + i) % 32];
        m_t++;
        if (m_t == m_len) m_active = 1'b0;
      end else if (scan_req) begin
        m_active = 1'b1;
        m_t      = 0;
        m_mode   = mode;
        m_snap   = pin;
        m_len    = f_len(mode);
      end
      if (safe) m_pout = OUT_SAFE;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  initial begin
    forever begin
      int  rd0;
      bit  in_ph;
      bit  rd_ph;
      @(negedge clk);
      if (cmp_en) begin
        rd0   = f_has_in(m_mode) ? N_IN : 0;
        in_ph = m_active && f_has_in(m_mode) && (m_t < N_IN);
        rd_ph = m_active && f_has_out(m_mode) && (m_t >= rd0) && (m_t < rd0 + N_OUT);
        chk("cyc_busy", 32'(busy), 32'(m_active));
        chk("cyc_done", 32'(done), 32'(m_active && (m_t == m_len - 1)));
        chk("cyc_we",   32'(im_we), 32'(in_ph));
        chk("cyc_pout", 32'(pout), 32'(m_pout));
        if (in_ph) begin
          chk("cyc_wr_addr", 32'(im_a), 32'((IN_BASE + m_t) % 32));
          chk("cyc_wr_data", 32'(im_di), 32'(m_snap[m_t]));
        end
        if (rd_ph)
          chk("cyc_rd_addr", 32'(im_a), 32'((OUT_BASE + m_t - rd0) % 32));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic preload_out(input logic [15:0] w);
    for (int i = 0; i < N_OUT; i++) begin
      ram0[OUT_BASE + i]  <= w[i];
      m_img[OUT_BASE + i]  = w[i];
    end
  endtask

  // Called #1 after an edge with the engine idle; returns #1 after the edge
  // that takes the engine back to IDLE.
  task automatic run_scan(input logic [1:0] md, input logic [15:0] pv, input int exp_lat,
                          input string tag, input int chg_at, input logic [15:0] chg_val,
                          input bit noise);
    int n;
    mode     = md;
    pin      = pv;
    scan_req = 1'b1;
    @(posedge clk); #1;
    scan_req = 1'b0;
    n = 1;
    while (!done && n < 200) begin
      if (n == chg_at) pin = chg_val;
      if (noise) begin
        scan_req = 1'($urandom_range(0, 1));
        pin      = 16'($urandom);
        if ($urandom_range(0, 7) == 0) safe = ~safe;
      end
      @(posedge clk); #1;
      n++;
    end
    scan_req = 1'b0;
    chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
    @(posedge clk); #1;
    $display("scan %s: mode=%b pin=%h latency=%0d pout=%h", tag, md, pv, n, pout);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [15:0] v;
    logic [15:0] w;
    logic [7:0]  w8;
    logic [1:0]  md;
    int          n, nd, prev, k;

    clr = 1'b1; scan_req = 1'b0; mode = 2'b00; safe = 1'b0; pin = 16'h0;
    scan_req_b = 1'b0; mode_b = 2'b00; safe_b = 1'b0; pin_b = 4'h0;
    for (int i = 0; i < 32; i++) begin
      ram0[i]  <= 1'b0;
      ram1[i]  <= 1'b0;
      m_img[i]  = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    clr    = 1'b0;
    cmp_en = 1'b1;

    // reset state
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_we",   32'(im_we), 32'd0);
    chk("rst_addr", 32'(im_a), 32'd0);
    chk("rst_di",   32'(im_di), 32'd0);
    chk("rst_pout", 32'(pout), 32'h5A5A);
    $display("reset: busy=%b pout=%h", busy, pout);

    // 1: both phases
    preload_out(16'h1234);
    run_scan(2'b10, 16'hA5C3, 34, "t1", 0, 16'h0, 1'b0);
    v = 16'hA5C3;
    for (int i = 0; i < 16; i++) chk("t1_ram_in", 32'(ram0[IN_BASE + i]), 32'(v[i]));
    chk("t1_pout", 32'(pout), 32'h1234);

    // 2: inputs only, PIN changes mid-scan
    run_scan(2'b00, 16'hFFFF, 17, "t2", 5, 16'h0000, 1'b0);
    for (int i = 0; i < 16; i++) chk("t2_ram_in", 32'(ram0[IN_BASE + i]), 32'd1);
    chk("t2_pout", 32'(pout), 32'h1234);

    // 3: SAFE during scan, then a normal scan
    preload_out(16'hFFFF);
    safe = 1'b1;
    run_scan(2'b10, 16'h3C3C, 34, "t3", 0, 16'h0, 1'b0);
    chk("t3_pout_safe", 32'(pout), 32'h0F0F);
    safe = 1'b0;
    @(posedge clk); #1;
    chk("t3_pout_hold", 32'(pout), 32'h0F0F);
    run_scan(2'b11, 16'h0001, 34, "t3b", 0, 16'h0, 1'b0);
    chk("t3_pout_after", 32'(pout), 32'hFFFF);

    // 4: reset in the middle of a scan
    preload_out(16'h8421);
    mode = 2'b10; pin = 16'h0F0F; scan_req = 1'b1;
    @(posedge clk); #1;
    scan_req = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_pout", 32'(pout), 32'h5A5A);
    nd = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    chk("t4_no_done", 32'(nd), 32'd0);
    $display("scan t4: reset mid-scan, busy=%b pout=%h", busy, pout);
    run_scan(2'b10, 16'h1111, 34, "t4b", 0, 16'h0, 1'b0);
    chk("t4_pout_after", 32'(pout), 32'h8421);

    // 5: request held high -> back-to-back scans
    mode = 2'b10; pin = 16'hBEEF; scan_req = 1'b1;
    n = 0; nd = 0; prev = -1;
    while (nd < 3 && n < 300) begin
      @(posedge clk); #1;
      n++;
      if (done) begin
        if (prev >= 0) chk("t5_interval", 32'(n - prev), 32'd35);
        prev = n;
        nd++;
      end
    end
    chk("t5_done_count", 32'(nd), 32'd3);
    scan_req = 1'b0;
    k = 0;
    while (busy && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk("t5_idle", 32'(busy), 32'd0);
    $display("scan t5: %0d back-to-back scans", nd);

    // randomized scans against the model
    for (int r = 0; r < 12; r++) begin
      md = 2'($urandom_range(0, 3));
      w  = 16'($urandom);
      preload_out(w);
      safe = ($urandom_range(0, 3) == 0);
      run_scan(md, 16'($urandom), f_len(md), "rnd", $urandom_range(1, 30), 16'($urandom), 1'b1);
      safe = 1'b0;
      @(posedge clk); #1;
    end
    for (int i = 0; i < 32; i++) chk("rnd_image", 32'(ram0[i]), 32'(m_img[i]));

    // 6: 4-in/8-out build, outputs only
    w8 = 8'($urandom);
    for (int i = 0; i < 8; i++) ram1[2 + i] <= w8[i];
    pin_b = 4'($urandom);
    mode_b = 2'b01; scan_req_b = 1'b1;
    @(posedge clk); #1;
    scan_req_b = 1'b0;
    n = 1;
    while (!done_b && n < 100) begin
      if (n <= 8) chk("t6_addr", 32'(im_a_b), 32'(2 + n - 1));
      chk("t6_we", 32'(im_we_b), 32'd0);
      @(posedge clk); #1;
      n++;
    end
    chk("t6_latency", 32'(n), 32'd10);
    chk("t6_pout", 32'(pout_b), 32'(w8));
    @(posedge clk); #1;
    chk("t6_idle", 32'(busy_b), 32'd0);
    $display("scan t6: mode=01 latency=%0d pout=%h", n, pout_b);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

endmodule
